// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back unit.
package wb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned FUNCT3_W   = 3;
  localparam int unsigned OFFSET_W   = 2;

  typedef enum logic {
    IDLE    = 1'b0,
    LD_WAIT = 1'b1
  } wb_state_e;

  // RV32I load funct3 encodings
  localparam logic [FUNCT3_W-1:0] F3_LB  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_LH  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_LW  = 3'b010;
  localparam logic [FUNCT3_W-1:0] F3_LBU = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load data selection and sign/zero extension.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0]   rdata,
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic [OFFSET_W-1:0] offset,
  output logic [DATA_W-1:0]   ext_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    // Halfword pick uses only offset[1]; misaligned halves are not split.
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    ext_c = rdata;
    case (funct3)
      F3_LB:   ext_c = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      F3_LH:   ext_c = {{(DATA_W-16){half_sel[15]}}, half_sel};
      F3_LBU:  ext_c = {{(DATA_W-8){1'b0}}, byte_sel};
      F3_LHU:  ext_c = {{(DATA_W-16){1'b0}}, half_sel};
      F3_LW:   ext_c = rdata;
      default: ext_c = rdata;
    endcase
  end

endmodule

// File: rtl/reg_wb_unit.sv
// Register-file write-back master: merges ALU results and load returns into one registered write port.
// Optional load-wait timeout enabled by defining WB_LD_TIMEOUT_EN.
module reg_wb_unit
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid_i,
  input  logic [ADDR_W-1:0]   alu_rd_i,
  input  logic [DATA_W-1:0]   alu_data_i,
  input  logic                ld_valid_i,
  input  logic [ADDR_W-1:0]   ld_rd_i,
  input  logic [FUNCT3_W-1:0] ld_funct3_i,
  input  logic [OFFSET_W-1:0] ld_offset_i,
  input  logic                ram_rvalid_i,
  input  logic [DATA_W-1:0]   ram_rdata_i,
  input  logic [ADDR_W-1:0]   rs1_addr_i,
  input  logic [ADDR_W-1:0]   rs2_addr_i,
  output logic                stall_o,
  output logic                load_pending_o,
  output logic [ADDR_W-1:0]   reg_waddr_o,
  output logic [DATA_W-1:0]   reg_wdata_o,
  output logic                reg_write_en_o
`ifdef WB_LD_TIMEOUT_EN
  ,
  output logic                ld_timeout_o
`endif
);

  wb_state_e           state;
  logic [ADDR_W-1:0]   pend_rd;
  logic [FUNCT3_W-1:0] pend_f3;
  logic [OFFSET_W-1:0] pend_off;

  logic                skid_valid;
  logic [ADDR_W-1:0]   skid_rd;
  logic [DATA_W-1:0]   skid_data;

  logic                in_wait_c;
  logic                pend_live_c;
  logic                ld_ret_c;
  logic                ld_acc_c;
  logic                alu_wr_c;
  logic [DATA_W-1:0]   ld_data_c;

  wb_load_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .rdata  (ram_rdata_i),
    .funct3 (pend_f3),
    .offset (pend_off),
    .ext_c  (ld_data_c)
  );

  assign in_wait_c   = (state == LD_WAIT);
  assign pend_live_c = in_wait_c && (pend_rd != '0);
  assign ld_ret_c    = in_wait_c && ram_rvalid_i;

  // Decode hold: skid full, load-use, second load, or WAW against the pending load
  assign stall_o = skid_valid
                || (pend_live_c && ((rs1_addr_i == pend_rd) || (rs2_addr_i == pend_rd)))
                || (in_wait_c && ld_valid_i)
                || (pend_live_c && alu_valid_i && (alu_rd_i == pend_rd));

  assign ld_acc_c = ld_valid_i && !stall_o && (state == IDLE);
  assign alu_wr_c = alu_valid_i && !stall_o && (alu_rd_i != '0);

  assign load_pending_o = in_wait_c;

`ifdef WB_LD_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_c;

  assign timeout_c = in_wait_c && !ram_rvalid_i
                  && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt     <= '0;
      ld_timeout_o <= 1'b0;
    end else begin
      ld_timeout_o <= timeout_c;
      if (ld_acc_c) begin
        wait_cnt <= '0;
      end else if (in_wait_c) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
  logic timeout_c;
  assign timeout_c = 1'b0;
`endif

  // Load FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pend_rd  <= '0;
      pend_f3  <= F3_LW;
      pend_off <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_acc_c) begin
            state    <= LD_WAIT;
            pend_rd  <= ld_rd_i;
            pend_f3  <= ld_funct3_i;
            pend_off <= ld_offset_i;
          end
        end
        LD_WAIT: begin
          if (ram_rvalid_i || timeout_c) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write port arbitration: load return, then skid entry, then fresh ALU result
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid     <= 1'b0;
      skid_rd        <= '0;
      skid_data      <= '0;
      reg_write_en_o <= 1'b0;
      reg_waddr_o    <= '0;
      reg_wdata_o    <= '0;
    end else begin
      reg_write_en_o <= 1'b0;
      if (ld_ret_c && (pend_rd != '0)) begin
        reg_write_en_o <= 1'b1;
        reg_waddr_o    <= pend_rd;
        reg_wdata_o    <= ld_data_c;
        if (alu_wr_c) begin
          skid_valid <= 1'b1;
          skid_rd    <= alu_rd_i;
          skid_data  <= alu_data_i;
        end
      end else if (skid_valid) begin
        reg_write_en_o <= 1'b1;
        reg_waddr_o    <= skid_rd;
        reg_wdata_o    <= skid_data;
        skid_valid     <= 1'b0;
      end else if (alu_wr_c) begin
        reg_write_en_o <= 1'b1;
        reg_waddr_o    <= alu_rd_i;
        reg_wdata_o    <= alu_data_i;
      end
    end
  end

endmodule

// File: tb/tb_reg_wb_unit.sv
// Scoreboard bench for reg_wb_unit; covers the timeout path when WB_LD_TIMEOUT_EN is defined.
module tb_reg_wb_unit;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_offset;
  logic        ram_rvalid;
  logic [31:0] ram_rdata;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        stall;
  logic        load_pending;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        reg_write_en;
`ifdef WB_LD_TIMEOUT_EN
  logic        ld_timeout;
`endif

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  reg_wb_unit #(
    .DATA_W         (32),
    .ADDR_W         (5),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .alu_valid_i    (alu_valid),
    .alu_rd_i       (alu_rd),
    .alu_data_i     (alu_data),
    .ld_valid_i     (ld_valid),
    .ld_rd_i        (ld_rd),
    .ld_funct3_i    (ld_funct3),
    .ld_offset_i    (ld_offset),
    .ram_rvalid_i   (ram_rvalid),
    .ram_rdata_i    (ram_rdata),
    .rs1_addr_i     (rs1_addr),
    .rs2_addr_i     (rs2_addr),
    .stall_o        (stall),
    .load_pending_o (load_pending),
    .reg_waddr_o    (reg_waddr),
    .reg_wdata_o    (reg_wdata),
    .reg_write_en_o (reg_write_en)
`ifdef WB_LD_TIMEOUT_EN
    ,
    .ld_timeout_o   (ld_timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d, input int c);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = c;
    q.push_back(e);
  endtask

  // Monitor: every write must match the oldest expected write, address, data and cycle
  always @(negedge clk) begin
    if (reg_write_en === 1'b1) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: waddr=%0d wdata=0x%08h at cycle %0d, none expected",
                 reg_waddr, reg_wdata, cyc);
      end else begin
        e = q.pop_front();
        if (reg_waddr !== e.addr || reg_wdata !== e.data || cyc != e.cyc) begin
          failures++;
          $display("FAIL write: got r%0d=0x%08h at cycle %0d expected r%0d=0x%08h at cycle %0d",
                   reg_waddr, reg_wdata, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                         input logic [31:0] data, input logic [31:0] exp);
    ld_valid  = 1'b1;
    ld_rd     = rd;
    ld_funct3 = f3;
    ld_offset = off;
    #1 chk("ld_issue_stall", {31'b0, stall}, 32'd0);
    tick();
    ld_valid = 1'b0;
    chk("ld_pending", {31'b0, load_pending}, 32'd1);
    tick();
    ram_rvalid = 1'b1;
    ram_rdata  = data;
    if (rd != 5'd0) push(rd, exp, cyc + 1);
    tick();
    ram_rvalid = 1'b0;
    chk("ld_done_pending", {31'b0, load_pending}, 32'd0);
  endtask

  logic [4:0]  t_rd   [7] = '{5'd3, 5'd3, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
  logic [2:0]  t_f3   [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b111};
  logic [1:0]  t_off  [7] = '{2'd2, 2'd2, 2'd3, 2'd1, 2'd1, 2'd1, 2'd0};
  logic [31:0] t_data [7] = '{32'h0080FF00, 32'h0080FF00, 32'h80011234, 32'h80011234,
                              32'hCAFEF00D, 32'h00007F00, 32'h12345678};
  logic [31:0] t_exp  [7] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00001234,
                              32'hCAFEF00D, 32'h0000007F, 32'h12345678};

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_funct3 = '0; ld_offset = '0;
    ram_rvalid = 1'b0; ram_rdata = '0;
    rs1_addr = '0; rs2_addr = '0;
    repeat (2) tick();
    chk("rst_wen", {31'b0, reg_write_en}, 32'd0);
    chk("rst_waddr", {27'b0, reg_waddr}, 32'd0);
    chk("rst_wdata", reg_wdata, 32'd0);
    chk("rst_pending", {31'b0, load_pending}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    rst = 1'b0;
    tick();

    // ALU only
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    push(5'd5, 32'h00001234, cyc + 1);
    #1 chk("alu_stall", {31'b0, stall}, 32'd0);
    tick();
    alu_valid = 1'b0;
    // rd=0 ALU result is dropped
    tick();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0;
    tick();

    // Load alignment table
    for (int i = 0; i < 7; i++) begin
      do_load(t_rd[i], t_f3[i], t_off[i], t_data[i], t_exp[i]);
    end
    tick();

    // Collision: load return and ALU result in the same cycle
    ld_valid = 1'b1; ld_rd = 5'd4; ld_funct3 = 3'b010; ld_offset = 2'd0;
    tick();
    ld_valid = 1'b0;
    tick();
    ram_rvalid = 1'b1; ram_rdata = 32'hAAAA0000;
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h77;
    push(5'd4, 32'hAAAA0000, cyc + 1);
    push(5'd6, 32'h00000077, cyc + 2);
    #1 chk("coll_stall0", {31'b0, stall}, 32'd0);
    tick();
    ram_rvalid = 1'b0; alu_valid = 1'b0;
    chk("coll_skid_stall", {31'b0, stall}, 32'd1);
    tick();
    chk("coll_drained_stall", {31'b0, stall}, 32'd0);
    tick();

    // Load-use, second load and WAW hazards against pending rd=7
    ld_valid = 1'b1; ld_rd = 5'd7; ld_funct3 = 3'b010; ld_offset = 2'd0;
    tick();
    ld_valid = 1'b0;
    rs2_addr = 5'd7;
    #1 chk("loaduse_rs2", {31'b0, stall}, 32'd1);
    tick();
    rs2_addr = 5'd0; rs1_addr = 5'd7;
    #1 chk("loaduse_rs1", {31'b0, stall}, 32'd1);
    tick();
    rs1_addr = 5'd0;
    #1 chk("no_hazard", {31'b0, stall}, 32'd0);
    ld_valid = 1'b1; ld_rd = 5'd9;
    #1 chk("second_load", {31'b0, stall}, 32'd1);
    tick();
    ld_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h99;
    #1 chk("waw_stall", {31'b0, stall}, 32'd1);
    tick();
    ram_rvalid = 1'b1; ram_rdata = 32'h11223344;
    push(5'd7, 32'h11223344, cyc + 1);
    #1 chk("waw_at_return", {31'b0, stall}, 32'd1);
    tick();
    ram_rvalid = 1'b0;
    push(5'd7, 32'h00000099, cyc + 1);
    #1 chk("waw_released", {31'b0, stall}, 32'd0);
    tick();
    alu_valid = 1'b0;
    tick();

    // rd=0 load: no hazard, no write; ALU rd=0 during wait also dropped
    ld_valid = 1'b1; ld_rd = 5'd0; ld_funct3 = 3'b010;
    tick();
    ld_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h5555;
    #1 chk("rd0_stall", {31'b0, stall}, 32'd0);
    chk("rd0_pending", {31'b0, load_pending}, 32'd1);
    tick();
    alu_valid = 1'b0;
    ram_rvalid = 1'b1; ram_rdata = 32'hFFFF0000;
    tick();
    ram_rvalid = 1'b0;
    chk("rd0_done", {31'b0, load_pending}, 32'd0);
    tick();

    // Reset while a load is pending; late return is ignored
    ld_valid = 1'b1; ld_rd = 5'd8; ld_funct3 = 3'b010;
    tick();
    ld_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_pending", {31'b0, load_pending}, 32'd0);
    tick();
    ram_rvalid = 1'b1; ram_rdata = 32'hDEAD0000;
    tick();
    ram_rvalid = 1'b0;
    chk("rst_mid_after", {31'b0, load_pending}, 32'd0);
    tick();

`ifdef WB_LD_TIMEOUT_EN
    // Timeout after 4 cycles in LD_WAIT, then a new load is accepted
    ld_valid = 1'b1; ld_rd = 5'd9; ld_funct3 = 3'b010;
    tick();
    ld_valid = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      chk("timeout_pulse", {31'b0, ld_timeout}, (i == 4) ? 32'd1 : 32'd0);
      chk("timeout_pending", {31'b0, load_pending}, (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    do_load(5'd9, 3'b010, 2'd0, 32'h0BADF00D, 32'h0BADF00D);
    tick();
`endif

    repeat (3) tick();
    chk("queue_empty", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
